// File: rtl/dmem_line_responder.sv
// Fixed-latency 256-bit line memory answering data-cache miss/write-back requests.
// One request in flight at a time; completion is a single-cycle ack with read data.
module dmem_line_responder #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int LINE_W  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [7:0] LOAD  = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t            state;
  logic [7:0]        count;
  logic [IDX_W-1:0]  req_idx;
  logic [LINE_W-1:0] req_data;
  logic              req_write;
  logic [LINE_W-1:0] mem [DEPTH];
  logic              access;

  // Byte offset and bits above the array size take no part in line selection.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

  assign access = (state == WAIT) && (count == 8'd0);
  assign busy_o = (state != IDLE);

  // No reset on the array: reset forces IDLE, so an aborted write never reaches access.
  always_ff @(posedge clk_i) begin
    if (access && req_write) begin
      mem[req_idx] <= req_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      count     <= 8'd0;
      req_idx   <= '0;
      req_data  <= '0;
      req_write <= 1'b0;
      ack_o     <= 1'b0;
      data_o    <= '0;
    end else begin
      ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i) begin
            req_idx   <= addr_i[IDX_W+4:5];
            req_data  <= data_i;
            req_write <= write_i;
            count     <= LOAD;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (count == 8'd0) begin
            if (!req_write) begin
              data_o <= mem[req_idx];
            end
            ack_o <= 1'b1;
            state <= ACK;
          end else begin
            count <= count - 8'd1;
          end
        end
        // The initiator may still hold enable here; returning to IDLE first avoids re-accepting it.
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: table of line requests plus hand-written
// sequences for async reset, aborted writes, held enable and LATENCY=1.
module tb_dmem_line_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic [255:0] rdata;
  logic         en, wr, ack, busy;

  logic [31:0]  addr1;
  logic [255:0] wdata1;
  logic [255:0] rdata1;
  logic         en1, wr1, ack1, busy1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_line_responder #(.LATENCY(10), .DEPTH(512), .LINE_W(256)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata), .enable_i(en),
    .write_i(wr), .ack_o(ack), .data_o(rdata), .busy_o(busy)
  );

  dmem_line_responder #(.LATENCY(1), .DEPTH(512), .LINE_W(256)) dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr1), .data_i(wdata1), .enable_i(en1),
    .write_i(wr1), .ack_o(ack1), .data_o(rdata1), .busy_o(busy1)
  );

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp_do;
    int           line;
  } vec_t;

  vec_t vecs[10];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on the LATENCY=10 port; inputs are scrambled during WAIT to prove the captured copy is used.
  task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [255:0] d,
                               input string name, output int lat);
    en = 1'b1; wr = w; addr = a; wdata = d;
    tick;
    checkOutput({name, " busy at accept"}, busy, 1);
    en = 1'b0; wr = ~w; addr = 32'hFFFF_FFE0; wdata = ~d;
    lat = -1;
    for (int n = 1; n <= 50; n++) begin
      tick;
      if (ack) begin
        lat = n;
        break;
      end
    end
    tick;
    checkOutput({name, " ack single cycle"}, ack, 0);
    checkOutput({name, " idle after ack"}, busy, 0);
  endtask

  task automatic req1(input bit w, input logic [31:0] a, input logic [255:0] d, output int lat);
    en1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d;
    tick;
    en1 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 5; n++) begin
      tick;
      if (ack1) begin
        lat = n;
        break;
      end
    end
    tick;
    checkOutput("lat1 ack single cycle", ack1, 0);
  endtask

  initial begin
    int lat;
    int nack;
    int acks[$];

    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    en1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;

    vecs[0] = '{1'b1, 32'h0000_0060, {32{8'hA5}}, 256'h0,        3};
    vecs[1] = '{1'b1, 32'h0000_3FE0, 256'h1FF,    256'h0,        511};
    vecs[2] = '{1'b0, 32'h0000_0060, 256'h0,      {32{8'hA5}},   3};
    vecs[3] = '{1'b1, 32'h0000_0080, 256'h1234,   {32{8'hA5}},   4};
    vecs[4] = '{1'b0, 32'h0000_0080, 256'h0,      256'h1234,     4};
    vecs[5] = '{1'b1, 32'h0000_009F, 256'hBEEF,   256'h1234,     4};
    vecs[6] = '{1'b0, 32'h0000_0080, 256'h0,      256'hBEEF,     4};
    vecs[7] = '{1'b1, 32'h0000_4000, 256'hCAFE,   256'hBEEF,     0};
    vecs[8] = '{1'b0, 32'h0000_0000, 256'h0,      256'hCAFE,     0};
    vecs[9] = '{1'b0, 32'h0000_3FE0, 256'h0,      256'h1FF,      511};

    tick;
    tick;
    checkOutput("reset ack", ack, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset data", rdata, 0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, $sformatf("v%0d", i), lat);
      checkOutput($sformatf("v%0d latency", i), lat, 10);
      checkOutput($sformatf("v%0d data_o", i), rdata, vecs[i].exp_do);
      checkOutput($sformatf("v%0d line", i), dut.mem[vecs[i].line],
                  vecs[i].wr ? vecs[i].wdata : vecs[i].exp_do);
    end

    // Async reset while ack is high must clear outputs without a clock edge.
    en = 1'b1; wr = 1'b0; addr = 32'h60;
    tick;
    en = 1'b0;
    lat = -1;
    for (int n = 1; n <= 50; n++) begin
      tick;
      if (ack) begin
        lat = n;
        break;
      end
    end
    checkOutput("pre-reset latency", lat, 10);
    checkOutput("pre-reset data", rdata, {32{8'hA5}});
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset ack", ack, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset data", rdata, 0);
    #2 rst = 1'b0;
    nack = 0;
    repeat (5) begin
      tick;
      if (ack) nack++;
    end
    checkOutput("idle after reset acks", nack, 0);

    // A write aborted by reset in WAIT must not commit.
    applyStimulus(1'b1, 32'hE0, 256'h77, "line7 preload", lat);
    checkOutput("line7 preload latency", lat, 10);
    en = 1'b1; wr = 1'b1; addr = 32'hE0; wdata = 256'hFF;
    tick;
    en = 1'b0;
    repeat (5) tick;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    checkOutput("abort busy", busy, 0);
    nack = 0;
    repeat (20) begin
      tick;
      if (ack) nack++;
    end
    checkOutput("abort acks", nack, 0);
    checkOutput("abort line7", dut.mem[7], 256'h77);
    applyStimulus(1'b0, 32'hE0, 256'h0, "post-abort read", lat);
    checkOutput("post-abort latency", lat, 10);
    checkOutput("post-abort data", rdata, 256'h77);

    // Held enable yields one ack per request, spaced LATENCY+2.
    applyStimulus(1'b1, 32'h20, 256'h11, "line1 preload", lat);
    checkOutput("line1 preload latency", lat, 10);
    en = 1'b1; wr = 1'b0; addr = 32'h20;
    tick;
    for (int c = 1; c <= 35; c++) begin
      tick;
      if (ack) acks.push_back(c);
    end
    en = 1'b0;
    tick;
    checkOutput("held ack count", acks.size(), 3);
    checkOutput("held ack 0", acks.size() > 0 ? acks[0] : -1, 10);
    checkOutput("held ack 1", acks.size() > 1 ? acks[1] : -1, 22);
    checkOutput("held ack 2", acks.size() > 2 ? acks[2] : -1, 34);
    checkOutput("held data", rdata, 256'h11);
    checkOutput("held idle", busy, 0);

    // LATENCY=1 instance: ack on the edge right after acceptance.
    req1(1'b1, 32'h40, 256'h22, lat);
    checkOutput("lat1 write latency", lat, 1);
    checkOutput("lat1 line2", dut1.mem[2], 256'h22);
    req1(1'b0, 32'h40, 256'h0, lat);
    checkOutput("lat1 read latency", lat, 1);
    checkOutput("lat1 read data", rdata1, 256'h22);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
